// File: rtl/packet_match_ctrl.sv
// rtl/packet_match_ctrl.sv - MAC packet sequencer that scores weighted comparator matches and keeps per-channel counters
module packet_match_ctrl #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 64,
    parameter int WGT_W    = 4,
    parameter int LAT      = 4,
    parameter bit SATURATE = 1'b1
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    update_done,
    input  logic                    sop,
    input  logic                    eop,
    input  logic                    valid,
    input  logic [5:0]              error,
    input  logic [1:0]              empty,
    input  logic [NUM_CH-1:0]       match,
    input  logic [NUM_CH*WGT_W-1:0] weights,
    input  logic [WGT_W+3:0]        threshold,
    input  logic                    clr_hits,
    output logic                    ready,
    output logic                    inc_addr,
    output logic                    clear,
    output logic [NUM_CH*CNT_W-1:0] hits,
    output logic [CNT_W-1:0]        pkt_cnt,
    output logic [CNT_W-1:0]        err_cnt
);

    typedef enum logic [2:0] {
        RESET, LOAD_CFG, IDLE, COMPARE, DRAIN, DECIDE, STORE, ERROR
    } state_t;

    localparam int         SUM_W      = WGT_W + 4;
    localparam logic [3:0] DRAIN_INIT = 4'(LAT - 1);

    state_t           state;
    state_t           next_state;
    logic [3:0]       wait_cnt;
    logic [SUM_W-1:0] sum;
    logic             err_start;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] cnt, input logic inc);
        if (!inc || (SATURATE && (&cnt)))
            return cnt;
        return cnt + CNT_W'(1);
    endfunction

    // Four spare bits keep the sum of up to 16 maximal weights from overflowing.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (match[i])
                sum = sum + SUM_W'(weights[i*WGT_W +: WGT_W]);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            RESET:    next_state = LOAD_CFG;
            LOAD_CFG: if (update_done) next_state = IDLE;
            IDLE:     if (sop && valid) next_state = COMPARE;
            COMPARE: begin
                if (eop)
                    next_state = DRAIN;
                else if (error != 6'd0)
                    next_state = ERROR;
            end
            DRAIN:    if (wait_cnt == 4'd0) next_state = DECIDE;
            DECIDE:   next_state = (sum >= threshold) ? STORE : IDLE;
            STORE:    next_state = IDLE;
            ERROR:    if (eop) next_state = IDLE;
            default:  next_state = RESET;
        endcase
    end

    assign err_start = (state == COMPARE) && (next_state == ERROR);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= RESET;
            wait_cnt <= 4'd0;
            ready    <= 1'b0;
            inc_addr <= 1'b0;
            clear    <= 1'b0;
            hits     <= '0;
            pkt_cnt  <= '0;
            err_cnt  <= '0;
        end else begin
            state <= next_state;

            if (state == COMPARE && next_state == DRAIN)
                wait_cnt <= DRAIN_INIT;
            else if (state == DRAIN && wait_cnt != 4'd0)
                wait_cnt <= wait_cnt - 4'd1;

            // In IDLE the FIFO is only read when it has enough bytes; otherwise keep the last enable.
            case (next_state)
                COMPARE, ERROR: ready <= 1'b1;
                IDLE:           if (empty < 2'd3) ready <= 1'b1;
                default:        ready <= 1'b0;
            endcase

            clear    <= (state == DECIDE);
            inc_addr <= (state == STORE);

            if (clr_hits) begin
                hits    <= '0;
                pkt_cnt <= '0;
                err_cnt <= '0;
            end else begin
                for (int i = 0; i < NUM_CH; i++)
                    hits[i*CNT_W +: CNT_W] <= bump(hits[i*CNT_W +: CNT_W], (state == DECIDE) && match[i]);
                pkt_cnt <= bump(pkt_cnt, state == DECIDE);
                err_cnt <= bump(err_cnt, err_start);
            end
        end
    end

endmodule
